instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle instruction sequencer stepping FETCH..JUMP by path class, with stage timeout and illegal-class detection.
// Latency: one cycle minimum per stage; a stage exits on the edge its qualified done is sampled high.
// Backpressure: each stage waits on its done handshake; a stalled stage faults to HALT after TIMEOUT cycles.
module instr_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt_req,
    input  logic        fetch_done,
    input  logic        decode_done,
    input  logic [3:0]  path_index,
    input  logic        exec_done,
    input  logic        mem_done,
    input  logic        wb_done,
    input  logic        jump_done,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        jump_en,
    output logic        jump,
    output logic [3:0]  path_q,
    output logic [2:0]  state,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic        timeout_err,
    output logic        illegal_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  path_r;
    logic [31:0] retire_cnt;
    logic [31:0] timer_q;
    logic        tout_r;
    logic        ill_r;

    logic        in_stage;
    logic        stage_done;
    logic        load_path;
    logic        set_ill;
    logic        set_tout;
    logic        retire;

    // Next-state logic: each done is only looked at in its own stage; timeout is the fallback when no done arrives.
    always_comb begin
        state_d    = state_q;
        in_stage   = 1'b0;
        stage_done = 1'b0;
        load_path  = 1'b0;
        set_ill    = 1'b0;
        set_tout   = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && !halt_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                in_stage   = 1'b1;
                stage_done = fetch_done;
                if (fetch_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                in_stage   = 1'b1;
                stage_done = decode_done;
                if (decode_done) begin
                    load_path = 1'b1;
                    case (path_index)
                        4'd0, 4'd1, 4'd2, 4'd3: state_d = S_EXEC;
                        4'd5, 4'd8:             state_d = S_JUMP;
                        4'd6:                   state_d = S_WB;
                        4'd15:                  state_d = S_HALT;
                        default: begin
                            state_d = S_HALT;
                            set_ill = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                in_stage   = 1'b1;
                stage_done = exec_done;
                if (exec_done) begin
                    // Only classes 0..3 reach EXEC, so the default arm is class 3.
                    case (path_r)
                        4'd0:       state_d = S_WB;
                        4'd1, 4'd2: state_d = S_MEM;
                        default:    state_d = S_JUMP;
                    endcase
                end
            end
            S_MEM: begin
                in_stage   = 1'b1;
                stage_done = mem_done;
                if (mem_done) state_d = (path_r == 4'd1) ? S_WB : S_JUMP;
            end
            S_WB: begin
                in_stage   = 1'b1;
                stage_done = wb_done;
                if (wb_done) state_d = S_JUMP;
            end
            S_JUMP: begin
                in_stage   = 1'b1;
                stage_done = jump_done;
                if (jump_done) begin
                    retire  = 1'b1;
                    state_d = (run && !halt_req) ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_HALT;
        endcase
        // A done on the expiry edge has already chosen a normal transition above.
        if (in_stage && !stage_done && (timer_q == TIMER_LAST)) begin
            state_d  = S_HALT;
            set_tout = 1'b1;
        end
    end

    // State, latched path class, retire counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            path_r     <= 4'd0;
            retire_cnt <= 32'd0;
            tout_r     <= 1'b0;
            ill_r      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_path) path_r <= path_index;
            if (retire) retire_cnt <= retire_cnt + 32'd1;
            if (set_tout) tout_r <= 1'b1;
            if (set_ill) ill_r <= 1'b1;
        end
    end

    // Stage timer restarts on every state change and counts stalled cycles within a stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= 32'd0;
        end else if (state_d != state_q) begin
            timer_q <= 32'd0;
        end else if (in_stage) begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXEC);
    assign mem_en      = (state_q == S_MEM);
    assign wb_en       = (state_q == S_WB);
    assign jump_en     = (state_q == S_JUMP);
    assign jump        = (state_q == S_JUMP) &&
                         ((path_r == 4'd5) || (path_r == 4'd6) || (path_r == 4'd8));
    assign path_q      = path_r;
    assign state       = state_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign instr_count = retire_cnt;
    assign timeout_err = tout_r;
    assign illegal_err = ill_r;

endmodule
